// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALURESULT = 2'b00;
  localparam logic [1:0] PC_ALUOUT    = 2'b01;
  localparam logic [1:0] PC_JUMP      = 2'b10;

  // States that sit on the memory handshake and are covered by the watchdog
  function automatic logic is_mem_wait(state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction-field, status and control bundle between the controller and the datapath.
interface mips_multicycle_ctrl_if;

  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       Illegal;
  logic       MemTimeout;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, Illegal, MemTimeout
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, Illegal, MemTimeout
  );

endinterface

// File: rtl/mips_alu_decoder.sv
// R-type Funct field to ALUControl code, flagging functs the ALU does not implement.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core with a memory-handshake watchdog.
// Define MIPS_CTRL_BNE_EN to add bne (opcode 000101) through the BRANCH state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [2:0]       dec_alu;
  logic             dec_illegal;
  logic             op_illegal;
  logic             mem_wait;
  logic             timeout;
  logic             branch_taken;

  mips_alu_decoder u_alu_dec (
    .funct         (bus.Funct),
    .alu_control   (dec_alu),
    .funct_illegal (dec_illegal)
  );

  assign mem_wait = is_mem_wait(state_q) && !bus.MemReady;
  assign timeout  = mem_wait && (cnt_q == CNT_LAST);

`ifdef MIPS_CTRL_BNE_EN
  logic bne_q, bne_d;

  assign branch_taken = bne_q ? !bus.Zero : bus.Zero;

  always_ff @(posedge clk) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end
`else
  assign branch_taken = bus.Zero;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    alu_ctrl_d = alu_ctrl_q;
    op_illegal = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    bne_d      = bne_q;
`endif
    if (mem_wait && !timeout) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      FETCH:    if (bus.MemReady) state_d = DECODE;
      DECODE: begin
`ifdef MIPS_CTRL_BNE_EN
        bne_d = (bus.Opcode == OP_BNE);
`endif
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d    = FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (bus.Opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.MemReady) state_d = MEMWB;
      MEMWRITE: if (bus.MemReady) state_d = FETCH;
      EXECUTE: begin
        alu_ctrl_d = dec_alu;
        state_d    = dec_illegal ? FETCH : ALUWB;
      end
      ADDIEX:   state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase

    // An expired watchdog abandons the access; a same-cycle MemReady never reaches here
    if (timeout) state_d = FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      alu_ctrl_q <= ALU_ADD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  always_comb begin
    bus.MemWrite   = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_B;
    bus.ALUControl = ALU_ADD;
    bus.PCSrc      = PC_ALURESULT;
    bus.PCEn       = 1'b0;
    bus.Illegal    = 1'b0;
    bus.MemTimeout = 1'b0;

    // Reset parks the datapath muxes on their FETCH setting with every strobe low
    if (reset) begin
      bus.ALUSrcB = SRCB_FOUR;
    end else begin
      bus.MemTimeout = timeout;
      case (state_q)
        FETCH: begin
          bus.ALUSrcB = SRCB_FOUR;
          bus.IRWrite = bus.MemReady;
          bus.PCEn    = bus.MemReady;
        end
        DECODE: begin
          bus.ALUSrcB = SRCB_IMM_SH2;
          bus.Illegal = op_illegal;
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        MEMREAD: bus.IorD = 1'b1;
        MEMWB: begin
          bus.MemtoReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        MEMWRITE: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = !timeout;
        end
        EXECUTE: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = dec_alu;
          bus.Illegal    = dec_illegal;
        end
        ALUWB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.ALUControl = alu_ctrl_q;
        end
        BRANCH: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = ALU_SUB;
          bus.PCSrc      = PC_ALUOUT;
          bus.PCEn       = branch_taken;
        end
        ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        ADDIWB:  bus.RegWrite = 1'b1;
        JUMP: begin
          bus.PCSrc = PC_JUMP;
          bus.PCEn  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction table, corner sequences and random traffic.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
    logic       mem_timeout;
  } ctl_t;

  typedef enum {
    PH_FETCH, PH_DECODE, PH_ADDR, PH_READ, PH_LOAD_WB, PH_WRITE,
    PH_EXEC, PH_R_WB, PH_BRANCH, PH_ADDI_EX, PH_ADDI_WB, PH_JUMP
  } phase_e;

  typedef phase_e plan_t[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         latency;
    int         reg_writes;
    int         mem_writes;
    int         illegals;
    int         branch_pc_loads;
    logic [2:0] wb_alu;
    int         load_wb_cycle;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic ctl_t sample();
    ctl_t s;
    s.mem_write   = bus.MemWrite;
    s.iord        = bus.IorD;
    s.ir_write    = bus.IRWrite;
    s.reg_dst     = bus.RegDst;
    s.memto_reg   = bus.MemtoReg;
    s.reg_write   = bus.RegWrite;
    s.alu_src_a   = bus.ALUSrcA;
    s.alu_src_b   = bus.ALUSrcB;
    s.alu_control = bus.ALUControl;
    s.pc_src      = bus.PCSrc;
    s.pc_en       = bus.PCEn;
    s.illegal     = bus.Illegal;
    s.mem_timeout = bus.MemTimeout;
    return s;
  endfunction

  // Reference rules: ALU code per funct (-1 = unsupported), legal opcodes, branch sense
  function automatic int alu_of(logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic logic is_bne(logic [5:0] op);
`ifdef MIPS_CTRL_BNE_EN
    return op == 6'b000101;
`else
    return (op == 6'b000101) && 1'b0;
`endif
  endfunction

  function automatic plan_t build_plan(logic [5:0] op, logic [5:0] fn);
    plan_t p;
    p.push_back(PH_FETCH);
    p.push_back(PH_DECODE);
    if (op == 6'b100011) begin
      p.push_back(PH_ADDR); p.push_back(PH_READ); p.push_back(PH_LOAD_WB);
    end else if (op == 6'b101011) begin
      p.push_back(PH_ADDR); p.push_back(PH_WRITE);
    end else if (op == 6'b000000) begin
      p.push_back(PH_EXEC);
      if (alu_of(fn) >= 0) p.push_back(PH_R_WB);
    end else if (op == 6'b000100 || is_bne(op)) begin
      p.push_back(PH_BRANCH);
    end else if (op == 6'b001000) begin
      p.push_back(PH_ADDI_EX); p.push_back(PH_ADDI_WB);
    end else if (op == 6'b000010) begin
      p.push_back(PH_JUMP);
    end
    return p;
  endfunction

  function automatic ctl_t exp_for(phase_e ph, logic ready, logic zero, logic [5:0] op, logic [5:0] fn);
    ctl_t e = '0;
    plan_t p = build_plan(op, fn);
    e.alu_control = 3'b010;
    case (ph)
      PH_FETCH:   begin e.alu_src_b = 2'b01; e.ir_write = ready; e.pc_en = ready; end
      PH_DECODE:  begin e.alu_src_b = 2'b11; e.illegal = (p.size() == 2); end
      PH_ADDR:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      PH_READ:    e.iord = 1'b1;
      PH_LOAD_WB: begin e.memto_reg = 1'b1; e.reg_write = 1'b1; end
      PH_WRITE:   begin e.iord = 1'b1; e.mem_write = 1'b1; end
      PH_EXEC: begin
        e.alu_src_a = 1'b1;
        if (alu_of(fn) < 0) e.illegal = 1'b1;
        else e.alu_control = 3'(alu_of(fn));
      end
      PH_R_WB:    begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.alu_control = 3'(alu_of(fn)); end
      PH_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01;
        e.pc_en = is_bne(op) ? !zero : zero;
      end
      PH_ADDI_EX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      PH_ADDI_WB: e.reg_write = 1'b1;
      PH_JUMP:    begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zero, input logic ready);
    bus.Opcode   = op;
    bus.Funct    = fn;
    bus.Zero     = zero;
    bus.MemReady = ready;
  endtask

  task automatic checkOutput(input string name, input ctl_t exp);
    ctl_t act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(6'b0, 6'b0, 1'b0, 1'b1);
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic runTableVector(input vec_t v);
    int lat = 0, reg_w = 0, mem_w = 0, ill = 0, br_pc = 0, load_c = 0;
    logic [2:0] wb_alu = 3'b010;
    logic done = 1'b0;
    doReset();
    for (int c = 1; c <= 12 && !done; c++) begin
      applyStimulus(v.op, v.funct, v.zero, 1'b1);
      settle();
      if (c > 1 && bus.IRWrite) begin
        lat  = c - 1;
        done = 1'b1;
      end else begin
        reg_w += int'(bus.RegWrite);
        mem_w += int'(bus.MemWrite);
        ill   += int'(bus.Illegal);
        if (c > 1) br_pc += int'(bus.PCEn);
        if (bus.RegWrite && bus.RegDst) wb_alu = bus.ALUControl;
        if (bus.RegWrite && bus.MemtoReg) load_c = c;
      end
      advance();
    end
    checkValue({v.name, " latency"}, lat, v.latency);
    checkValue({v.name, " reg_writes"}, reg_w, v.reg_writes);
    checkValue({v.name, " mem_writes"}, mem_w, v.mem_writes);
    checkValue({v.name, " illegal_pulses"}, ill, v.illegals);
    checkValue({v.name, " pc_loads_after_fetch"}, br_pc, v.branch_pc_loads);
    checkValue({v.name, " wb_alu"}, int'(wb_alu), int'(v.wb_alu));
    checkValue({v.name, " load_wb_cycle"}, load_c, v.load_wb_cycle);
  endtask

  task automatic runRandomInstr();
    logic [5:0] op, fn;
    logic       z;
    logic       ready, aborted;
    int         stall, sel;
    plan_t      plan;
    ctl_t       e;
    logic [5:0] fn_list [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    sel = $urandom_range(0, 9);
    case (sel)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2, 3, 9: op = 6'b000000;
      4: op = 6'b000100;
      5: op = 6'b001000;
      6: op = 6'b000010;
      7: op = 6'b000101;
      default: op = 6'($urandom);
    endcase
    fn = (sel == 9) ? 6'($urandom) : fn_list[$urandom_range(0, 4)];
    z  = 1'($urandom_range(0, 1));
    plan = build_plan(op, fn);
    aborted = 1'b0;
    for (int i = 0; i < plan.size() && !aborted; i++) begin
      if (plan[i] == PH_FETCH || plan[i] == PH_READ || plan[i] == PH_WRITE) begin
        stall = $urandom_range(0, 4);
        if (stall == 4) stall = 6;
        for (int k = 0; k <= stall && !aborted; k++) begin
          ready = (k == stall);
          e = exp_for(plan[i], ready, z, op, fn);
          if (!ready && k == TMO - 1) begin
            e.mem_write   = 1'b0;
            e.mem_timeout = 1'b1;
            aborted       = 1'b1;
          end
          applyStimulus(op, fn, z, ready);
          settle();
          checkOutput({"rand ", plan[i].name()}, e);
          advance();
        end
      end else begin
        applyStimulus(op, fn, z, 1'($urandom_range(0, 1)));
        settle();
        checkOutput({"rand ", plan[i].name()}, exp_for(plan[i], bus.MemReady, z, op, fn));
        advance();
      end
    end
  endtask

  vec_t table_v[$];

  initial begin
    vec_t v;
    ctl_t e;
    reset = 1'b1;
    applyStimulus(6'b0, 6'b0, 1'b0, 1'b0);

    //           name        op         funct      z  lat rw mw il pc  wb_alu  load
    table_v.push_back('{"lw",       6'b100011, 6'b000000, 0, 5, 1, 0, 0, 0, 3'b010, 5});
    table_v.push_back('{"sw",       6'b101011, 6'b000000, 0, 4, 0, 1, 0, 0, 3'b010, 0});
    table_v.push_back('{"add",      6'b000000, 6'b100000, 0, 4, 1, 0, 0, 0, 3'b010, 0});
    table_v.push_back('{"sub",      6'b000000, 6'b100010, 0, 4, 1, 0, 0, 0, 3'b110, 0});
    table_v.push_back('{"and",      6'b000000, 6'b100100, 0, 4, 1, 0, 0, 0, 3'b000, 0});
    table_v.push_back('{"or",       6'b000000, 6'b100101, 0, 4, 1, 0, 0, 0, 3'b001, 0});
    table_v.push_back('{"slt",      6'b000000, 6'b101010, 0, 4, 1, 0, 0, 0, 3'b111, 0});
    table_v.push_back('{"badfunct", 6'b000000, 6'b000111, 0, 3, 0, 0, 1, 0, 3'b010, 0});
    table_v.push_back('{"beq_z1",   6'b000100, 6'b000000, 1, 3, 0, 0, 0, 1, 3'b010, 0});
    table_v.push_back('{"beq_z0",   6'b000100, 6'b000000, 0, 3, 0, 0, 0, 0, 3'b010, 0});
    table_v.push_back('{"addi",     6'b001000, 6'b000000, 0, 4, 1, 0, 0, 0, 3'b010, 0});
    table_v.push_back('{"j",        6'b000010, 6'b000000, 0, 3, 0, 0, 0, 1, 3'b010, 0});
    table_v.push_back('{"op3f",     6'b111111, 6'b000000, 0, 2, 0, 0, 1, 0, 3'b010, 0});
`ifdef MIPS_CTRL_BNE_EN
    table_v.push_back('{"bne_z0",   6'b000101, 6'b000000, 0, 3, 0, 0, 0, 1, 3'b010, 0});
    table_v.push_back('{"bne_z1",   6'b000101, 6'b000000, 1, 3, 0, 0, 0, 0, 3'b010, 0});
`else
    table_v.push_back('{"bne_off",  6'b000101, 6'b000000, 0, 2, 0, 0, 1, 0, 3'b010, 0});
`endif

    // Reset state: FETCH mux settings, strobes held low even with MemReady high
    advance();
    applyStimulus(6'b0, 6'b0, 1'b0, 1'b1);
    settle();
    checkOutput("reset_outputs", exp_for(PH_FETCH, 1'b0, 1'b0, 6'b0, 6'b0));
    advance();
    reset = 1'b0;
    settle();
    checkOutput("first_fetch", exp_for(PH_FETCH, 1'b1, 1'b0, 6'b0, 6'b0));
    advance();

    foreach (table_v[i]) runTableVector(table_v[i]);

    // sw whose write never completes: watchdog fires on the 4th wait cycle
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(6'b101011, 6'b0, 1'b0, 1'b1);
      settle();
      advance();
    end
    for (int k = 1; k <= TMO; k++) begin
      e = exp_for(PH_WRITE, 1'b0, 1'b0, 6'b101011, 6'b0);
      if (k == TMO) begin
        e.mem_write   = 1'b0;
        e.mem_timeout = 1'b1;
      end
      applyStimulus(6'b101011, 6'b0, 1'b0, 1'b0);
      settle();
      checkOutput($sformatf("timeout_wait%0d", k), e);
      advance();
    end
    settle();
    checkOutput("timeout_then_fetch", exp_for(PH_FETCH, 1'b0, 1'b0, 6'b101011, 6'b0));
    advance();

    // Reset landing on the ALUWB cycle suppresses the write and restarts at FETCH
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
      settle();
      advance();
    end
    reset = 1'b1;
    settle();
    checkOutput("reset_in_aluwb", exp_for(PH_FETCH, 1'b0, 1'b0, 6'b0, 6'b100000));
    advance();
    reset = 1'b0;
    settle();
    checkOutput("after_reset_fetch", exp_for(PH_FETCH, 1'b1, 1'b0, 6'b0, 6'b100000));
    advance();

    doReset();
    for (int n = 0; n < 400; n++) runRandomInstr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
